// File: rtl/seg7_scan_if.sv
// Bundle between user logic and the seg7_scan display driver.
// master = user side (drives load/value/dp_in), slave = the driver itself.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic [6:0]            segments;
    logic                  dp;
    logic [DIGITS-1:0]     digit_en;
    logic                  frame_done;

    modport master (
        output load, value, dp_in,
        input  segments, dp, digit_en, frame_done
    );

    modport slave (
        input  load, value, dp_in,
        output segments, dp, digit_en, frame_done
    );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed, double-buffered hex 7-segment scanner with ghost blanking.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZ_BLANK_EN.
module seg7_scan #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);
    localparam int   CW  = $clog2(SCAN_DIV);
    localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [CW-1:0]         scan_cnt_q,   scan_cnt_d;
    logic [IW-1:0]         digit_idx_q,  digit_idx_d;
    logic [4*DIGITS-1:0]   disp_val_q,   disp_val_d;
    logic [DIGITS-1:0]     disp_dp_q,    disp_dp_d;
    logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]     shadow_dp_q,  shadow_dp_d;
    logic                  pending_q,    pending_d;
    logic [6:0]            segments_q,   segments_d;
    logic                  dp_q,         dp_d;
    logic [DIGITS-1:0]     digit_en_q,   digit_en_d;
    logic                  frame_done_q, frame_done_d;

    logic                  scan_last, idx_last, frame_end;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blank;
    logic [6:0]            dec;
    logic [DIGITS-1:0]     en_raw;
    logic [DIGITS-1:0]     lz_blank;

`ifdef SEG7_SCAN_LZ_BLANK_EN
    // A digit goes dark when it and every more-significant nibble are zero.
    genvar gi;
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
        if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign lz_blank[gi] = ~|disp_val_q[4*DIGITS-1:4*gi];
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        scan_last   = (scan_cnt_q == CW'(SCAN_DIV - 1));
        idx_last    = (digit_idx_q == IW'(DIGITS - 1));
        frame_end   = scan_last && idx_last;

        scan_cnt_d  = scan_last ? '0 : scan_cnt_q + CW'(1);
        digit_idx_d = digit_idx_q;
        if (scan_last) begin
            digit_idx_d = idx_last ? '0 : digit_idx_q + IW'(1);
        end

        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        if (frame_end) begin
            // A load landing on the frame boundary bypasses the shadow.
            if (bus.load) begin
                disp_val_d = bus.value;
                disp_dp_d  = bus.dp_in;
                pending_d  = 1'b0;
            end else if (pending_q) begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
                pending_d  = 1'b0;
            end
        end else if (bus.load) begin
            shadow_val_d = bus.value;
            shadow_dp_d  = bus.dp_in;
            pending_d    = 1'b1;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        en_raw    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_idx_q == IW'(k)) begin
                cur_nib   = disp_val_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                cur_blank = lz_blank[k];
                en_raw[k] = (scan_cnt_q != '0);
            end
        end
    end

    always_comb begin
        dec = '0;
        case (cur_nib)
            4'h0: dec = 7'b0111111;
            4'h1: dec = 7'b0000110;
            4'h2: dec = 7'b1011011;
            4'h3: dec = 7'b1001111;
            4'h4: dec = 7'b1100110;
            4'h5: dec = 7'b1101101;
            4'h6: dec = 7'b1111101;
            4'h7: dec = 7'b0000111;
            4'h8: dec = 7'b1111111;
            4'h9: dec = 7'b1100111;
            4'hA: dec = 7'b1110111;
            4'hB: dec = 7'b1111100;
            4'hC: dec = 7'b0111001;
            4'hD: dec = 7'b1011110;
            4'hE: dec = 7'b1111001;
            default: dec = 7'b1110001;
        endcase
    end

    always_comb begin
        segments_d   = (cur_blank ? 7'b0 : dec) ^ {7{POL}};
        dp_d         = cur_dp ^ POL;
        digit_en_d   = en_raw ^ {DIGITS{POL}};
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q   <= '0;
            digit_idx_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            segments_q   <= {7{POL}};
            dp_q         <= POL;
            digit_en_q   <= {DIGITS{POL}};
            frame_done_q <= 1'b0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            digit_idx_q  <= digit_idx_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            segments_q   <= segments_d;
            dp_q         <= dp_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.segments   = segments_q;
    assign bus.dp         = dp_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: 4-digit active-high, 4-digit active-low and 1-digit instances.
module tb_seg7_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seg7_scan_if #(.DIGITS(4)) a_if ();
    seg7_scan_if #(.DIGITS(4)) b_if ();
    seg7_scan_if #(.DIGITS(1)) c_if ();

    seg7_scan #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    seg7_scan #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    seg7_scan #(.DIGITS(1), .SCAN_DIV(4), .ACTIVE_LOW(0)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1100111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] w, input int k);
`ifdef SEG7_SCAN_LZ_BLANK_EN
        if (k > 0 && (w >> (4*k)) == 16'h0) return 7'b0;
`endif
        return seg_of(4'((w >> (4*k)) & 16'hF));
    endfunction

    task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
        a_if.load  = 1'b1;
        a_if.value = v;
        a_if.dp_in = d;
        $display("load value=%h dp=%b", v, d);
    endtask

    // One 16-cycle frame on instance A, starting aligned at scan state 0.
    task automatic run_frame(input string name, input logic [15:0] ew, input logic [3:0] ed,
                             input int la, input logic [15:0] va, input logic [3:0] da,
                             input int lb, input logic [15:0] vb, input logic [3:0] db);
        for (int s = 0; s < 16; s++) begin
            int k;
            int c;
            k = s / 4;
            c = s % 4;
            if (s == la) drive_load(va, da);
            else if (s == lb) drive_load(vb, db);
            @(posedge clk);
            @(negedge clk);
            a_if.load = 1'b0;
            check($sformatf("%s_en_s%0d", name, s), 32'(a_if.digit_en), (c == 0) ? 32'd0 : (32'd1 << k));
            check($sformatf("%s_seg_s%0d", name, s), 32'(a_if.segments), 32'(exp_seg(ew, k)));
            check($sformatf("%s_dp_s%0d", name, s), 32'(a_if.dp), 32'(ed[k]));
            check($sformatf("%s_fd_s%0d", name, s), 32'(a_if.frame_done), (s == 15) ? 32'd1 : 32'd0);
        end
        $display("frame %s expected word=%h dp=%b", name, ew, ed);
    endtask

    initial begin
        logic [3:0] prev;
        a_if.load = 1'b0; a_if.value = '0; a_if.dp_in = '0;
        b_if.load = 1'b0; b_if.value = '0; b_if.dp_in = '0;
        c_if.load = 1'b0; c_if.value = '0; c_if.dp_in = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_seg", 32'(a_if.segments), 32'h0);
        check("rst_a_dp", 32'(a_if.dp), 32'h0);
        check("rst_a_en", 32'(a_if.digit_en), 32'h0);
        check("rst_a_fd", 32'(a_if.frame_done), 32'h0);
        check("rst_b_seg", 32'(b_if.segments), 32'h7F);
        check("rst_b_dp", 32'(b_if.dp), 32'h1);
        check("rst_b_en", 32'(b_if.digit_en), 32'hF);
        check("rst_b_fd", 32'(b_if.frame_done), 32'h0);
        rst_n = 1'b1;

        run_frame("f1", 16'h0000, 4'b0000, 0, 16'h1234, 4'b0011, -1, 16'h0, 4'b0);
        run_frame("f2", 16'h1234, 4'b0011, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
        run_frame("f3", 16'h1234, 4'b0011, 2, 16'hAAAA, 4'b0000, -1, 16'h0, 4'b0);
        run_frame("f4", 16'hAAAA, 4'b0000, 5, 16'h5555, 4'b1111, -1, 16'h0, 4'b0);
        run_frame("f5", 16'h5555, 4'b1111, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
        run_frame("f6", 16'h5555, 4'b1111, 3, 16'h1111, 4'b0001, 9, 16'h2222, 4'b0010);
        run_frame("f7", 16'h2222, 4'b0010, 15, 16'hBEEF, 4'b0101, -1, 16'h0, 4'b0);
        run_frame("f8", 16'hBEEF, 4'b0101, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
        run_frame("f9", 16'hBEEF, 4'b0101, 0, 16'h0070, 4'b1000, -1, 16'h0, 4'b0);
        run_frame("f10", 16'h0070, 4'b1000, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);

        // Pending load followed by reset must be discarded.
        drive_load(16'h9999, 4'b1111);
        @(posedge clk);
        @(negedge clk);
        a_if.load = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mrst_a_seg", 32'(a_if.segments), 32'h0);
        check("mrst_a_en", 32'(a_if.digit_en), 32'h0);
        check("mrst_a_fd", 32'(a_if.frame_done), 32'h0);
        rst_n = 1'b1;
        run_frame("r1", 16'h0000, 4'b0000, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
        run_frame("r2", 16'h0000, 4'b0000, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);

        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst2_b_seg", 32'(b_if.segments), 32'h7F);
        check("rst2_b_en", 32'(b_if.digit_en), 32'hF);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b_s0_en", 32'(b_if.digit_en), 32'hF);
        check("b_s0_seg", 32'(b_if.segments), 32'h40);
        check("b_s0_dp", 32'(b_if.dp), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("b_s1_en", 32'(b_if.digit_en), 32'hE);
        check("b_s1_seg", 32'(b_if.segments), 32'h40);
        check("b_s1_fd", 32'(b_if.frame_done), 32'h0);

        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_c_seg", 32'(c_if.segments), 32'h0);
        check("rst_c_en", 32'(c_if.digit_en), 32'h0);
        rst_n = 1'b1;
        prev = 4'h0;
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < 8; s++) begin
                if (s == 0) begin
                    c_if.load  = 1'b1;
                    c_if.value = 4'(n);
                    $display("c load value=%h", 4'(n));
                end
                @(posedge clk);
                @(negedge clk);
                c_if.load = 1'b0;
                check($sformatf("c%0d_en_s%0d", n, s), 32'(c_if.digit_en), ((s % 4) == 0) ? 32'd0 : 32'd1);
                check($sformatf("c%0d_fd_s%0d", n, s), 32'(c_if.frame_done), ((s % 4) == 3) ? 32'd1 : 32'd0);
                check($sformatf("c%0d_seg_s%0d", n, s), 32'(c_if.segments),
                      32'((s < 4) ? seg_of(prev) : seg_of(4'(n))));
            end
            prev = 4'(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
